memory_1_to_4_arbiter: RTL and testbench

//  Client-side front end for one shared single_port_mem of FULL_MEM_DEPTH words.

---
 rtl/memory_1_to_4_arbiter.sv | 267 ++++++++++++++++++++++++++
 tb/tb_memory_1_to_4_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_1_to_4_arbiter.sv
// memory_1_to_4_arbiter
//   Four-client round-robin front end for one shared single-port memory.
//   Each client sees a private window of SINGLE_MEM_DEPTH words; local
//   addresses are offset by a fixed per-client base into the shared array.
//   Read data comes back on one shared bus, tagged by a per-client strobe.
//
//   Optional build macro: MEM_ARB_RD_PIPE_EN
//     defined   -> extra output register on read data, rd_valid and addr_err
//                  (read latency 2, mem_rd_dout resets to 0)
//     undefined -> read latency 1, mem_rd_dout straight from memory q

// Plain synchronous single-port RAM: registered read, one access per cycle.
module single_port_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 28,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write plus registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= din;
    end
    q <= mem[addr];
  end

endmodule

module memory_1_to_4_arbiter #(
  parameter int WIDTH                = 64,
  parameter int SINGLE_MEM_DEPTH     = 7,
  parameter int FULL_MEM_DEPTH       = 28,
  parameter int SINGLE_MEM_DEPTH_LOG = $clog2(SINGLE_MEM_DEPTH),
  parameter int FULL_MEM_DEPTH_LOG   = $clog2(FULL_MEM_DEPTH),
  parameter int MEM_0_START_ADDR     = 0,
  parameter int MEM_1_START_ADDR     = SINGLE_MEM_DEPTH,
  parameter int MEM_2_START_ADDR     = 2 * SINGLE_MEM_DEPTH,
  parameter int MEM_3_START_ADDR     = 3 * SINGLE_MEM_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst_n,

  input  logic                            mem_0_req,
  input  logic                            mem_0_we,
  input  logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_0_addr,
  input  logic [WIDTH-1:0]                mem_0_din,
  output logic                            mem_0_gnt,
  output logic                            mem_0_rd_valid,

  input  logic                            mem_1_req,
  input  logic                            mem_1_we,
  input  logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_1_addr,
  input  logic [WIDTH-1:0]                mem_1_din,
  output logic                            mem_1_gnt,
  output logic                            mem_1_rd_valid,

  input  logic                            mem_2_req,
  input  logic                            mem_2_we,
  input  logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_2_addr,
  input  logic [WIDTH-1:0]                mem_2_din,
  output logic                            mem_2_gnt,
  output logic                            mem_2_rd_valid,

  input  logic                            mem_3_req,
  input  logic                            mem_3_we,
  input  logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_3_addr,
  input  logic [WIDTH-1:0]                mem_3_din,
  output logic                            mem_3_gnt,
  output logic                            mem_3_rd_valid,

  output logic [WIDTH-1:0]                mem_rd_dout,
  output logic                            addr_err
);

  localparam int SAW = SINGLE_MEM_DEPTH_LOG;
  localparam int FAW = FULL_MEM_DEPTH_LOG;

  // Handshake: a client raises req (with we/addr/din stable) and holds it
  // until it sees gnt. The access is transferred in the cycle where
  // req & gnt are both 1; the client may drop or change req the next cycle.
  // gnt is combinational from req and the round-robin pointer.

  // ---------------------------------------------------------------------
  // Client bundling
  // ---------------------------------------------------------------------
  logic [3:0]           req_vec;
  logic [3:0]           we_vec;
  logic [SAW-1:0]       addr_arr [4];
  logic [WIDTH-1:0]     din_arr  [4];
  logic [FAW-1:0]       base_arr [4];

  assign req_vec     = {mem_3_req, mem_2_req, mem_1_req, mem_0_req};
  assign we_vec      = {mem_3_we, mem_2_we, mem_1_we, mem_0_we};
  assign addr_arr[0] = mem_0_addr;
  assign addr_arr[1] = mem_1_addr;
  assign addr_arr[2] = mem_2_addr;
  assign addr_arr[3] = mem_3_addr;
  assign din_arr[0]  = mem_0_din;
  assign din_arr[1]  = mem_1_din;
  assign din_arr[2]  = mem_2_din;
  assign din_arr[3]  = mem_3_din;
  assign base_arr[0] = FAW'(MEM_0_START_ADDR);
  assign base_arr[1] = FAW'(MEM_1_START_ADDR);
  assign base_arr[2] = FAW'(MEM_2_START_ADDR);
  assign base_arr[3] = FAW'(MEM_3_START_ADDR);

  // ---------------------------------------------------------------------
  // Round-robin arbitration
  // ---------------------------------------------------------------------
  logic [1:0] rr_ptr;
  logic [1:0] cand;
  logic [1:0] gnt_idx;
  logic       gnt_found;
  logic       any_gnt;
  logic [3:0] gnt_vec;

  // Search from the pointer upward (mod 4); first requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = 2'd0;
    cand      = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand = rr_ptr + 2'(i);
      if (!gnt_found && req_vec[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Grants are held off entirely while reset is asserted.
  assign any_gnt = gnt_found & rst_n;
  assign gnt_vec = any_gnt ? (4'b0001 << gnt_idx) : 4'b0000;

  assign mem_0_gnt = gnt_vec[0];
  assign mem_1_gnt = gnt_vec[1];
  assign mem_2_gnt = gnt_vec[2];
  assign mem_3_gnt = gnt_vec[3];

  // Pointer moves just past the winner; unchanged on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 2'd0;
    end else if (any_gnt) begin
      rr_ptr <= gnt_idx + 2'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Address mapping and memory command
  // ---------------------------------------------------------------------
  logic [SAW-1:0]   sel_addr;
  logic [WIDTH-1:0] sel_din;
  logic             sel_we;
  logic             sel_in_range;
  logic [FAW-1:0]   sel_phys;

  logic             mem_wr_en;
  logic [FAW-1:0]   mem_addr;
  logic [WIDTH-1:0] mem_din;
  logic [WIDTH-1:0] mem_q;

  // Steer the winning client's command onto the memory port.
  always_comb begin
    sel_addr     = addr_arr[gnt_idx];
    sel_din      = din_arr[gnt_idx];
    sel_we       = we_vec[gnt_idx];
    sel_in_range = (32'(sel_addr) < 32'(SINGLE_MEM_DEPTH));
    sel_phys     = FAW'(sel_addr) + base_arr[gnt_idx];
  end

  // Out-of-range accesses never touch the array; idle parks on address 0.
  always_comb begin
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    if (any_gnt && sel_in_range) begin
      mem_wr_en = sel_we;
      mem_addr  = sel_phys;
      mem_din   = sel_din;
    end
  end

  single_port_mem #(
    .WIDTH (WIDTH),
    .DEPTH (FULL_MEM_DEPTH),
    .AW    (FAW)
  ) u_mem (
    .clk   (clk),
    .wr_en (mem_wr_en),
    .addr  (mem_addr),
    .din   (mem_din),
    .q     (mem_q)
  );

  // ---------------------------------------------------------------------
  // Read tag pipe: tracks who owns the data coming out of the memory
  // ---------------------------------------------------------------------
  logic       s1_valid;
  logic [1:0] s1_client;
  logic       s1_oor;
  logic       s1_err;

  // Capture owner and range status of each granted access; cleared by reset
  // so reads in flight are never returned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_client <= 2'd0;
      s1_oor    <= 1'b0;
      s1_err    <= 1'b0;
    end else begin
      s1_valid  <= any_gnt & ~sel_we;
      s1_client <= gnt_idx;
      s1_oor    <= any_gnt & ~sel_in_range;
      s1_err    <= any_gnt & ~sel_in_range;
    end
  end

  logic [3:0]       s1_rd_valid;
  logic [WIDTH-1:0] s1_rd_dout;

  assign s1_rd_valid = s1_valid ? (4'b0001 << s1_client) : 4'b0000;
  assign s1_rd_dout  = s1_oor ? '0 : mem_q;

`ifdef MEM_ARB_RD_PIPE_EN
  logic [3:0]       s2_rd_valid;
  logic [WIDTH-1:0] s2_rd_dout;
  logic             s2_err;

  // Output register stage: adds one cycle of latency, keeps 1 read/cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_rd_valid <= 4'b0000;
      s2_rd_dout  <= '0;
      s2_err      <= 1'b0;
    end else begin
      s2_rd_valid <= s1_rd_valid;
      s2_rd_dout  <= s1_rd_dout;
      s2_err      <= s1_err;
    end
  end

  assign mem_0_rd_valid = s2_rd_valid[0];
  assign mem_1_rd_valid = s2_rd_valid[1];
  assign mem_2_rd_valid = s2_rd_valid[2];
  assign mem_3_rd_valid = s2_rd_valid[3];
  assign mem_rd_dout    = s2_rd_dout;
  assign addr_err       = s2_err;
`else
  assign mem_0_rd_valid = s1_rd_valid[0];
  assign mem_1_rd_valid = s1_rd_valid[1];
  assign mem_2_rd_valid = s1_rd_valid[2];
  assign mem_3_rd_valid = s1_rd_valid[3];
  assign mem_rd_dout    = s1_rd_dout;
  assign addr_err       = s1_err;
`endif

endmodule

// File: tb/tb_memory_1_to_4_arbiter.sv
// Directed bench for memory_1_to_4_arbiter (both latency builds).
module tb_memory_1_to_4_arbiter;

`ifdef MEM_ARB_RD_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Client drive
  logic [3:0]  req_vec;
  logic [3:0]  we_vec;
  logic [2:0]  addr [4];
  logic [63:0] din  [4];

  // Observed
  logic [3:0]  gnt_vec;
  logic [3:0]  rdv_vec;
  logic [63:0] dout;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q [$];

  memory_1_to_4_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_0_req      (req_vec[0]),
    .mem_0_we       (we_vec[0]),
    .mem_0_addr     (addr[0]),
    .mem_0_din      (din[0]),
    .mem_0_gnt      (gnt_vec[0]),
    .mem_0_rd_valid (rdv_vec[0]),
    .mem_1_req      (req_vec[1]),
    .mem_1_we       (we_vec[1]),
    .mem_1_addr     (addr[1]),
    .mem_1_din      (din[1]),
    .mem_1_gnt      (gnt_vec[1]),
    .mem_1_rd_valid (rdv_vec[1]),
    .mem_2_req      (req_vec[2]),
    .mem_2_we       (we_vec[2]),
    .mem_2_addr     (addr[2]),
    .mem_2_din      (din[2]),
    .mem_2_gnt      (gnt_vec[2]),
    .mem_2_rd_valid (rdv_vec[2]),
    .mem_3_req      (req_vec[3]),
    .mem_3_we       (we_vec[3]),
    .mem_3_addr     (addr[3]),
    .mem_3_din      (din[3]),
    .mem_3_gnt      (gnt_vec[3]),
    .mem_3_rd_valid (rdv_vec[3]),
    .mem_rd_dout    (dout),
    .addr_err       (addr_err)
  );

  // ---------------- driver tasks ----------------
  task automatic idle_all;
    req_vec = 4'b0000;
    we_vec  = 4'b0000;
  endtask

  task automatic apply_reset;
    @(negedge clk);
    idle_all();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One isolated access by client k; returns grant seen in the request cycle
  // and the read-side outputs LAT cycles after the transfer.
  task automatic access(input int k, input logic w, input logic [2:0] a,
                        input logic [63:0] d, output logic [3:0] g,
                        output logic [3:0] v, output logic [63:0] q,
                        output logic e);
    @(negedge clk);
    req_vec[k] = 1'b1;
    we_vec[k]  = w;
    addr[k]    = a;
    din[k]     = d;
    #1 g = gnt_vec;
    @(negedge clk);
    req_vec[k] = 1'b0;
    we_vec[k]  = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    v = rdv_vec;
    q = dout;
    e = addr_err;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    @(negedge clk);
    rst_n   = 1'b0;
    req_vec = 4'b1111;
    #1;
    checks++;
    if (gnt_vec !== 4'b0000) begin
      errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt_vec);
    end
    checks++;
    if (rdv_vec !== 4'b0000) begin
      errors++; $display("FAIL reset_rd_valid: got %b expected 0000", rdv_vec);
    end
    checks++;
    if (addr_err !== 1'b0) begin
      errors++; $display("FAIL reset_addr_err: got %b expected 0", addr_err);
    end
`ifdef MEM_ARB_RD_PIPE_EN
    checks++;
    if (dout !== 64'h0) begin
      errors++; $display("FAIL reset_dout: got %h expected 0", dout);
    end
`endif
    idle_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read;
    logic [3:0] g, v; logic [63:0] q; logic e;
    access(0, 1'b1, 3'd3, 64'hA5, g, v, q, e);
    checks++;
    if (g !== 4'b0001) begin
      errors++; $display("FAIL wr0_gnt: got %b expected 0001", g);
    end
    checks++;
    if (v !== 4'b0000) begin
      errors++; $display("FAIL wr0_no_valid: got %b expected 0000", v);
    end
    access(0, 1'b0, 3'd3, 64'h0, g, v, q, e);
    checks++;
    if (g !== 4'b0001) begin
      errors++; $display("FAIL rd0_gnt: got %b expected 0001", g);
    end
    checks++;
    if (v !== 4'b0001) begin
      errors++; $display("FAIL rd0_valid: got %b expected 0001", v);
    end
    checks++;
    if (q !== 64'hA5) begin
      errors++; $display("FAIL rd0_dout: got %h expected a5", q);
    end
    checks++;
    if (e !== 1'b0) begin
      errors++; $display("FAIL rd0_err: got %b expected 0", e);
    end
  endtask

  // Write then read the same word in consecutive cycles, then check latency.
  task automatic test_back_to_back;
    @(negedge clk);
    req_vec[1] = 1'b1; we_vec[1] = 1'b1; addr[1] = 3'd2; din[1] = 64'hBEEF;
    @(negedge clk);
    we_vec[1] = 1'b0;
    @(negedge clk);
    idle_all();
    if (LAT == 2) begin
      checks++;
      if (rdv_vec !== 4'b0000) begin
        errors++; $display("FAIL b2b_early_valid: got %b expected 0000", rdv_vec);
      end
      @(negedge clk);
    end
    checks++;
    if (rdv_vec !== 4'b0010) begin
      errors++; $display("FAIL b2b_valid: got %b expected 0010", rdv_vec);
    end
    checks++;
    if (dout !== 64'hBEEF) begin
      errors++; $display("FAIL b2b_dout: got %h expected beef", dout);
    end
    @(negedge clk);
    checks++;
    if (rdv_vec !== 4'b0000) begin
      errors++; $display("FAIL b2b_valid_pulse: got %b expected 0000", rdv_vec);
    end
  endtask

  // All four clients read continuously from pointer 0.
  task automatic test_round_robin;
    logic [3:0] g, v; logic [63:0] q; logic e;
    logic [1:0] exp_c;
    for (int k = 0; k < 4; k++) begin
      access(k, 1'b1, 3'd0, 64'h100 + 64'(k), g, v, q, e);
    end
    apply_reset();
    exp_q.delete();
    for (int c = 0; c < 8 + LAT; c++) begin
      @(negedge clk);
      if (c >= LAT) begin
        exp_c = exp_q.pop_front();
        checks++;
        if (rdv_vec !== (4'b0001 << exp_c)) begin
          errors++; $display("FAIL rr_valid[%0d]: got %b expected %b", c, rdv_vec, 4'b0001 << exp_c);
        end
        checks++;
        if (dout !== 64'h100 + 64'(exp_c)) begin
          errors++; $display("FAIL rr_dout[%0d]: got %h expected %h", c, dout, 64'h100 + 64'(exp_c));
        end
      end
      if (c < 8) begin
        req_vec = 4'b1111;
        we_vec  = 4'b0000;
        for (int k = 0; k < 4; k++) addr[k] = 3'd0;
        #1;
        checks++;
        if (gnt_vec !== (4'b0001 << (c % 4))) begin
          errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", c, gnt_vec, 4'b0001 << (c % 4));
        end
        exp_q.push_back(2'(c % 4));
      end else begin
        idle_all();
      end
    end
  endtask

  task automatic test_windows;
    logic [3:0] g, v; logic [63:0] q; logic e;
    access(1, 1'b1, 3'd6, 64'h1111, g, v, q, e);
    access(2, 1'b1, 3'd6, 64'h1234, g, v, q, e);
    access(1, 1'b0, 3'd6, 64'h0, g, v, q, e);
    checks++;
    if (v !== 4'b0010) begin
      errors++; $display("FAIL win1_valid: got %b expected 0010", v);
    end
    checks++;
    if (q !== 64'h1111) begin
      errors++; $display("FAIL win1_dout: got %h expected 1111", q);
    end
    access(2, 1'b0, 3'd6, 64'h0, g, v, q, e);
    checks++;
    if (v !== 4'b0100) begin
      errors++; $display("FAIL win2_valid: got %b expected 0100", v);
    end
    checks++;
    if (q !== 64'h1234) begin
      errors++; $display("FAIL win2_dout: got %h expected 1234", q);
    end
  endtask

  task automatic test_out_of_range;
    logic [3:0] g, v; logic [63:0] q; logic e;
    access(0, 1'b1, 3'd0, 64'h5555, g, v, q, e);
    access(3, 1'b1, 3'd7, 64'hDEAD, g, v, q, e);
    checks++;
    if (g !== 4'b1000) begin
      errors++; $display("FAIL oor_wr_gnt: got %b expected 1000", g);
    end
    checks++;
    if (e !== 1'b1) begin
      errors++; $display("FAIL oor_wr_err: got %b expected 1", e);
    end
    checks++;
    if (v !== 4'b0000) begin
      errors++; $display("FAIL oor_wr_valid: got %b expected 0000", v);
    end
    @(negedge clk);
    checks++;
    if (addr_err !== 1'b0) begin
      errors++; $display("FAIL oor_err_pulse: got %b expected 0", addr_err);
    end
    access(0, 1'b0, 3'd0, 64'h0, g, v, q, e);
    checks++;
    if (q !== 64'h5555) begin
      errors++; $display("FAIL oor_no_write: got %h expected 5555", q);
    end
    access(3, 1'b0, 3'd7, 64'h0, g, v, q, e);
    checks++;
    if (v !== 4'b1000) begin
      errors++; $display("FAIL oor_rd_valid: got %b expected 1000", v);
    end
    checks++;
    if (q !== 64'h0) begin
      errors++; $display("FAIL oor_rd_dout: got %h expected 0", q);
    end
    checks++;
    if (e !== 1'b1) begin
      errors++; $display("FAIL oor_rd_err: got %b expected 1", e);
    end
  endtask

  task automatic test_reset_in_flight;
    @(negedge clk);
    req_vec = 4'b0100; we_vec = 4'b0000; addr[2] = 3'd1;
    @(negedge clk);
    req_vec = 4'b1000; addr[3] = 3'd1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rdv_vec !== 4'b0000) begin
      errors++; $display("FAIL flight_valid_in_reset: got %b expected 0000", rdv_vec);
    end
    idle_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (rdv_vec !== 4'b0000) begin
        errors++; $display("FAIL flight_valid_after[%0d]: got %b expected 0000", c, rdv_vec);
      end
    end
    req_vec = 4'b1010;
    #1;
    checks++;
    if (gnt_vec !== 4'b0010) begin
      errors++; $display("FAIL flight_first_gnt: got %b expected 0010", gnt_vec);
    end
    @(negedge clk);
    idle_all();
    repeat (LAT + 1) @(negedge clk);
  endtask

  task automatic test_fairness;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_vec = 4'b0010; we_vec = 4'b0000; addr[1] = 3'd0;
      #1;
      checks++;
      if (gnt_vec !== 4'b0010) begin
        errors++; $display("FAIL solo1_gnt[%0d]: got %b expected 0010", c, gnt_vec);
      end
    end
    @(negedge clk);
    req_vec = 4'b0011; addr[0] = 3'd0;
    #1;
    checks++;
    if (gnt_vec !== 4'b0001) begin
      errors++; $display("FAIL fair0_gnt: got %b expected 0001", gnt_vec);
    end
    @(negedge clk);
    #1;
    checks++;
    if (gnt_vec !== 4'b0010) begin
      errors++; $display("FAIL fair1_gnt: got %b expected 0010", gnt_vec);
    end
    @(negedge clk);
    idle_all();
    repeat (LAT + 1) @(negedge clk);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_n = 1'b1;
    idle_all();
    for (int k = 0; k < 4; k++) begin
      addr[k] = 3'd0;
      din[k]  = 64'h0;
    end
    test_reset();
    test_write_read();
    test_back_to_back();
    test_round_robin();
    test_windows();
    test_out_of_range();
    test_reset_in_flight();
    test_fairness();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
